// File: rtl/sb_cfg_pkg.sv
// Shared types and constants for the switch-box configuration loader.
package sb_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        CHECK  = 2'd3
    } state_t;

    localparam int SB_SEL_W = 16;
    localparam int FIELD_W  = 2;
    localparam logic [FIELD_W-1:0] SEL_RESERVED = 2'b11;

    // Number of select bits carried by one frame for a chain of num_sb boxes.
    function automatic int total_bits(input int num_sb);
        return num_sb * SB_SEL_W;
    endfunction

endpackage

// File: rtl/sb_cfg_checker.sv
// Combinational frame checker: even parity over the select word plus its
// parity bit, and detection of any 2-bit field holding the reserved code.
module sb_cfg_checker
    import sb_cfg_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] shadow,
    input  logic             par,
    output logic             parity_ok,
    output logic             reserved_hit
);

    // Evaluate both frame checks from the shadow word and the latched parity bit.
    always_comb begin
        parity_ok    = ~((^shadow) ^ par);
        reserved_hit = 1'b0;
        for (int i = 0; i < WIDTH / FIELD_W; i++) begin
            if (shadow[i*FIELD_W +: FIELD_W] == SEL_RESERVED) begin
                reserved_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sb_cfg_ctrl.sv
// Serial configuration loader for a chain of switch boxes. Bits are shifted
// into a shadow register; only a frame passing parity and reserved-code
// checks is copied, in one edge, onto the active select bus.
module sb_cfg_ctrl
    import sb_cfg_pkg::*;
#(
    parameter int NUM_SB   = 4,
    parameter int SB_SEL_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_start,
    input  logic                       cfg_abort,
    input  logic                       cfg_valid,
    input  logic                       cfg_bit,
    output logic                       cfg_ready,
    output logic [NUM_SB*SB_SEL_W-1:0] sel_out,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int TOTAL = total_bits(NUM_SB);
    localparam int CW    = $clog2(TOTAL + 1);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [TOTAL-1:0] shadow;
    logic             par_q;
    logic [TOTAL-1:0] sel_q;
    logic             done_q;
    logic             err_q;
    logic             accept;
    logic             last_data;
    logic             parity_ok;
    logic             reserved_hit;

    assign accept    = cfg_valid && cfg_ready;
    assign last_data = (cnt == CW'(TOTAL - 1));

    sb_cfg_checker #(
        .WIDTH (TOTAL)
    ) u_checker (
        .shadow       (shadow),
        .par          (par_q),
        .parity_ok    (parity_ok),
        .reserved_hit (reserved_hit)
    );

    // State register; reset drops any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and ready decode; abort outranks start while a frame is open.
    always_comb begin
        state_nxt = state;
        cfg_ready = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                cfg_ready = 1'b1;
                if (cfg_abort) begin
                    state_nxt = IDLE;
                end else if (cfg_start) begin
                    state_nxt = SHIFT;
                end else if (accept && last_data) begin
                    state_nxt = PARITY;
                end
            end
            PARITY: begin
                cfg_ready = 1'b1;
                if (cfg_abort) begin
                    state_nxt = IDLE;
                end else if (cfg_start) begin
                    state_nxt = SHIFT;
                end else if (accept) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Shadow shifting, parity capture, and the atomic commit out of CHECK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            shadow <= '0;
            par_q  <= 1'b0;
            sel_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (!cfg_abort) begin
                        if (cfg_start) begin
                            cnt <= '0;
                        end else if (accept) begin
                            shadow <= {shadow[TOTAL-2:0], cfg_bit};
                            cnt    <= cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (!cfg_abort) begin
                        if (cfg_start) begin
                            cnt <= '0;
                        end else if (accept) begin
                            par_q <= cfg_bit;
                        end
                    end
                end
                CHECK: begin
                    if (parity_ok && !reserved_hit) begin
                        sel_q  <= shadow;
                        done_q <= 1'b1;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    assign sel_out = sel_q;
    assign busy    = (state != IDLE);
    assign done    = done_q;
    assign err     = err_q;

endmodule
